// File: rtl/oq_pkg.sv
// Shared definitions for the output-queue memory write path: word layout,
// arbiter state encoding and a constant ceil-log2 helper.
package oq_pkg;
   localparam int MEM_WORD_WIDTH = 202;
   localparam int LAST_BIT       = 1;
   localparam int WORD_STATE_LO  = 2;
   localparam int WORD_STATE_HI  = 4;
   localparam int STROBE_LO      = 5;
   localparam int STROBE_HI      = 9;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction
endpackage

// File: rtl/oq_rr_pick.sv
// Round-robin picker: rotates the request vector so ptr lands on bit 0,
// takes the lowest set bit, then maps that offset back to a queue index.
module oq_rr_pick
   import oq_pkg::*;
#(
   parameter int N     = 5,
   parameter int IDX_W = clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);

   logic [N-1:0]     rot_s;
   logic [IDX_W-1:0] off_s;
   logic [IDX_W:0]   sum_s;
   logic             found_s;

   // Rotate, priority-encode from the pointer, un-rotate the winning offset.
   always_comb begin
      rot_s   = N'({req, req} >> ptr);
      off_s   = '0;
      found_s = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot_s[i]) begin
            off_s   = IDX_W'(i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      sum_s = {1'b0, ptr} + {1'b0, off_s};
      if (sum_s >= N_EXT) begin
         sum_s = sum_s - N_EXT;
      end else begin
         sum_s = sum_s;
      end
      idx = sum_s[IDX_W-1:0];
      if (found_s) begin
         gnt = {{(N-1){1'b0}}, 1'b1} << idx;
      end else begin
         gnt = '0;
      end
      any = found_s;
   end
endmodule

// File: rtl/oq_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter from the per-output-queue FIFOs onto the
// single SRAM write port; a granted queue keeps the port until its last word.
module oq_pkt_rr_arbiter #(
   parameter int NUM_QUEUES    = 5,
   parameter int DATA_WIDTH    = oq_pkg::MEM_WORD_WIDTH,
   parameter int LAST_BIT      = oq_pkg::LAST_BIT,
   parameter int QID_WIDTH     = 3,
   parameter int PKT_CNT_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0] din,
   input  logic [NUM_QUEUES-1:0]            din_valid,
   output logic [NUM_QUEUES-1:0]            din_ready,
   input  logic [NUM_QUEUES-1:0]            queue_enable,
   output logic [DATA_WIDTH-1:0]            dout,
   output logic                             dout_valid,
   input  logic                             dout_ready,
   output logic [QID_WIDTH-1:0]             queue_id,
   output logic                             dout_sop,
   output logic [PKT_CNT_WIDTH-1:0]         pkt_count
);
   import oq_pkg::*;

   localparam int               PTR_W  = clog2(NUM_QUEUES);
   localparam logic [PTR_W-1:0] LAST_Q = PTR_W'(NUM_QUEUES - 1);

   arb_state_e                state_r, state_nxt_s;
   logic [PTR_W-1:0]          ptr_r, ptr_nxt_s, lock_q_r, lock_q_nxt_s;
   logic [PTR_W-1:0]          pick_idx_s, sel_idx_s;
   logic [NUM_QUEUES-1:0]     req_s, gnt_s, pop_s;
   logic                      pick_any_s, adv_s, move_s, sop_s, last_s;
   logic [DATA_WIDTH-1:0]     sel_word_s;

   function automatic logic [PTR_W-1:0] next_q(input logic [PTR_W-1:0] q);
      if (q == LAST_Q) begin
         return '0;
      end else begin
         return q + PTR_W'(1);
      end
   endfunction

   assign req_s     = din_valid & queue_enable;
   assign din_ready = pop_s;

   oq_rr_pick #(
      .N     (NUM_QUEUES),
      .IDX_W (PTR_W)
   ) u_pick (
      .req (req_s),
      .ptr (ptr_r),
      .gnt (gnt_s),
      .idx (pick_idx_s),
      .any (pick_any_s)
   );

   // Grant/transfer decision; a last word returns to IDLE so the next packet is picked without a bubble.
   always_comb begin
      adv_s        = ~dout_valid | dout_ready;
      state_nxt_s  = state_r;
      ptr_nxt_s    = ptr_r;
      lock_q_nxt_s = lock_q_r;
      sel_idx_s    = lock_q_r;
      move_s       = 1'b0;
      sop_s        = 1'b0;
      pop_s        = '0;
      case (state_r)
         IDLE: begin
            sel_idx_s = pick_idx_s;
            sop_s     = 1'b1;
            if (pick_any_s && adv_s && !reset) begin
               move_s = 1'b1;
               pop_s  = gnt_s;
            end else begin
               move_s = 1'b0;
            end
         end
         LOCKED: begin
            if (din_valid[lock_q_r] && adv_s && !reset) begin
               move_s           = 1'b1;
               pop_s[lock_q_r]  = 1'b1;
            end else begin
               move_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      sel_word_s = din[sel_idx_s*DATA_WIDTH +: DATA_WIDTH];
      last_s     = sel_word_s[LAST_BIT];
      if (move_s) begin
         if (last_s) begin
            state_nxt_s = IDLE;
            ptr_nxt_s   = next_q(sel_idx_s);
         end else begin
            state_nxt_s  = LOCKED;
            lock_q_nxt_s = sel_idx_s;
         end
      end else begin
         state_nxt_s = state_nxt_s;
      end
   end

   // State, pointer and registered output stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         ptr_r      <= '0;
         lock_q_r   <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         queue_id   <= '0;
         dout_sop   <= 1'b0;
         pkt_count  <= '0;
      end else begin
         state_r  <= state_nxt_s;
         ptr_r    <= ptr_nxt_s;
         lock_q_r <= lock_q_nxt_s;
         if (move_s) begin
            dout       <= sel_word_s;
            dout_valid <= 1'b1;
            queue_id   <= QID_WIDTH'(sel_idx_s);
            dout_sop   <= sop_s;
            if (last_s) begin
               pkt_count <= pkt_count + PKT_CNT_WIDTH'(1);
            end else begin
               pkt_count <= pkt_count;
            end
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
         end else begin
            dout_valid <= dout_valid;
         end
      end
   end
endmodule

// File: tb/tb_oq_pkt_rr_arbiter.sv
// Bench for oq_pkt_rr_arbiter: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, random traffic, 8-queue wrap.
module tb_oq_pkt_rr_arbiter;
   localparam int NQ  = 5;
   localparam int DW  = 202;
   localparam int LB  = 1;
   localparam int QW  = 3;
   localparam int CW  = 32;
   localparam int N8  = 8;
   localparam int DW8 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset = 1'b1;
   logic [NQ*DW-1:0]     din = '0;
   logic [NQ-1:0]        din_valid = '0;
   logic [NQ-1:0]        din_ready;
   logic [NQ-1:0]        queue_enable = '1;
   logic [DW-1:0]        dout;
   logic                 dout_valid;
   logic                 dout_ready = 1'b1;
   logic [QW-1:0]        queue_id;
   logic                 dout_sop;
   logic [CW-1:0]        pkt_count;

   logic [N8*DW8-1:0]    din8 = '0;
   logic [N8-1:0]        din_valid8 = '0;
   logic [N8-1:0]        din_ready8;
   logic [N8-1:0]        queue_enable8 = '1;
   logic [DW8-1:0]       dout8;
   logic                 dout_valid8;
   logic                 dout_ready8 = 1'b1;
   logic [2:0]           queue_id8;
   logic                 dout_sop8;
   logic [7:0]           pkt_count8;

   oq_pkt_rr_arbiter dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .queue_enable(queue_enable), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .queue_id(queue_id), .dout_sop(dout_sop), .pkt_count(pkt_count)
   );

   oq_pkt_rr_arbiter #(
      .NUM_QUEUES(N8), .DATA_WIDTH(DW8), .LAST_BIT(1), .QID_WIDTH(3), .PKT_CNT_WIDTH(8)
   ) dut8 (
      .clk(clk), .reset(reset), .din(din8), .din_valid(din_valid8), .din_ready(din_ready8),
      .queue_enable(queue_enable8), .dout(dout8), .dout_valid(dout_valid8), .dout_ready(dout_ready8),
      .queue_id(queue_id8), .dout_sop(dout_sop8), .pkt_count(pkt_count8)
   );

   typedef struct {
      int            qid;
      bit            sop;
      logic [DW-1:0] word;
      int            cyc;
   } acc_t;

   acc_t          acc_q [$];
   logic [DW-1:0] fifo [NQ][$];
   int            hold [NQ];
   int            popped [NQ];
   int            gap_pct = 0;
   int            rdy_mode = 0;
   int            pidx = 0;
   int            cyc = 0;
   int            first_rdy = -1;
   int            errors = 0;
   int            checks = 0;

   // reference model: whole-packet ownership, pointer and counter
   bit            m_valid;
   logic [DW-1:0] m_dout;
   int            m_qid;
   bit            m_sop;
   logic [CW-1:0] m_cnt;
   int            m_ptr;
   int            m_owner;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_word(input int seq, input bit last);
      logic [DW-1:0] w;
      w = '0;
      w[DW-1 -: 32] = $urandom;
      w[47:16]      = seq;
      w[0]          = 1'($urandom_range(1));
      w[LB]         = last;
      return w;
   endfunction

   task automatic push_pkt(input int q, input int n, input int seq0);
      for (int i = 0; i < n; i++) fifo[q].push_back(mk_word(seq0 + i, i == n - 1));
   endtask

   task automatic drive_inputs();
      logic [3:0] pat;
      pat = 4'b1001;
      for (int q = 0; q < NQ; q++) begin
         if (fifo[q].size() > 0 && hold[q] == 0 && int'($urandom_range(99)) >= gap_pct) begin
            din_valid[q]    = 1'b1;
            din[q*DW +: DW] = fifo[q][0];
         end else begin
            din_valid[q]    = 1'b0;
            din[q*DW +: DW] = {DW{1'b1}};
         end
      end
      case (rdy_mode)
         0: dout_ready = 1'b1;
         1: dout_ready = ($urandom_range(99) < 70);
         default: begin
            dout_ready = pat[pidx % 4];
            pidx++;
         end
      endcase
   endtask

   function automatic int model_grant();
      int g;
      g = -1;
      if (reset || !(!m_valid || dout_ready)) return -1;
      if (m_owner >= 0) begin
         if (din_valid[m_owner]) g = m_owner;
      end else begin
         for (int k = 0; k < NQ; k++) begin
            int q;
            q = (m_ptr + k) % NQ;
            if (g < 0 && din_valid[q] && queue_enable[q]) g = q;
         end
      end
      return g;
   endfunction

   task automatic cycle();
      int            g;
      logic [NQ-1:0] exp_rdy;
      logic [DW-1:0] w;
      acc_t          a;
      @(negedge clk);
      g       = model_grant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("din_ready", 256'(din_ready), 256'(exp_rdy));
      if (first_rdy < 0 && din_ready != '0) first_rdy = cyc;
      if (!reset && dout_valid && dout_ready) begin
         a.qid = int'(queue_id); a.sop = dout_sop; a.word = dout; a.cyc = cyc;
         acc_q.push_back(a);
      end
      @(posedge clk);
      if (reset) begin
         m_valid = 1'b0; m_dout = '0; m_qid = 0; m_sop = 1'b0;
         m_cnt = '0; m_ptr = 0; m_owner = -1;
      end else if (g >= 0) begin
         w       = fifo[g].pop_front();
         popped[g]++;
         m_dout  = w; m_qid = g; m_sop = (m_owner < 0); m_valid = 1'b1;
         if (w[LB]) begin
            m_owner = -1;
            m_ptr   = (g + 1) % NQ;
            m_cnt   = m_cnt + 1;
         end else begin
            m_owner = g;
         end
      end else if (dout_ready) begin
         m_valid = 1'b0;
      end
      cyc++;
      #1;
      check("dout_valid", 256'(dout_valid), 256'(m_valid));
      check("pkt_count", 256'(pkt_count), 256'(m_cnt));
      if (m_valid) begin
         check("dout", 256'(dout), 256'(m_dout));
         check("queue_id", 256'(queue_id), 256'(m_qid));
         check("dout_sop", 256'(dout_sop), 256'(m_sop));
      end
      for (int q = 0; q < NQ; q++) if (hold[q] > 0) hold[q]--;
      drive_inputs();
   endtask

   task automatic run(input int n);
      drive_inputs();
      repeat (n) cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int q = 0; q < NQ; q++) begin
         fifo[q].delete();
         hold[q] = 0;
      end
      drive_inputs();
      cycle();
      reset = 1'b0;
      for (int q = 0; q < NQ; q++) popped[q] = 0;
      acc_q.delete();
      first_rdy = -1;
   endtask

   initial begin
      int exp_q [9];
      int trig, q, seqc, total_pkts, left;
      logic [DW8-1:0] w8 [3];
      logic [N8-1:0]  exp_r8 [3];
      int             exp_q8 [3];

      // reset values
      do_reset();
      check("rst_dout_valid", 256'(dout_valid), 256'(0));
      check("rst_dout", 256'(dout), 256'(0));
      check("rst_queue_id", 256'(queue_id), 256'(0));
      check("rst_dout_sop", 256'(dout_sop), 256'(0));
      check("rst_pkt_count", 256'(pkt_count), 256'(0));
      check("rst_din_ready", 256'(din_ready), 256'(0));

      // single 4-word packet on q2
      push_pkt(2, 4, 10);
      run(10);
      check("single_words", 256'(acc_q.size()), 256'(4));
      if (acc_q.size() == 4) begin
         check("single_latency", 256'(acc_q[0].cyc), 256'(first_rdy + 1));
         check("single_contig", 256'(acc_q[3].cyc - acc_q[0].cyc), 256'(3));
         for (int i = 0; i < 4; i++) begin
            check("single_qid", 256'(acc_q[i].qid), 256'(2));
            check("single_sop", 256'(acc_q[i].sop), 256'(i == 0));
            check("single_seq", 256'(acc_q[i].word[47:16]), 256'(10 + i));
         end
      end
      check("single_pkt_count", 256'(pkt_count), 256'(1));

      // fairness: q0, q1, q4 with three 2-word packets each
      do_reset();
      for (int p = 0; p < 3; p++) begin
         push_pkt(0, 2, 1000 + p * 10);
         push_pkt(1, 2, 1100 + p * 10);
         push_pkt(4, 2, 1400 + p * 10);
      end
      exp_q = '{0, 1, 4, 0, 1, 4, 0, 1, 4};
      run(25);
      check("fair_words", 256'(acc_q.size()), 256'(18));
      if (acc_q.size() == 18) begin
         for (int p = 0; p < 9; p++) check("fair_order", 256'(acc_q[2*p].qid), 256'(exp_q[p]));
         check("fair_no_bubble", 256'(acc_q[17].cyc - acc_q[0].cyc), 256'(17));
      end
      check("fair_pkt_count", 256'(pkt_count), 256'(9));

      // backpressure on a 5-word q3 packet
      do_reset();
      rdy_mode = 2;
      pidx     = 0;
      push_pkt(3, 5, 50);
      run(20);
      check("bp_words", 256'(acc_q.size()), 256'(5));
      if (acc_q.size() == 5) begin
         for (int i = 0; i < 5; i++) check("bp_seq", 256'(acc_q[i].word[47:16]), 256'(50 + i));
      end
      rdy_mode = 0;

      // mid-packet valid drop on q1 with mask cleared; q0 waits for q1's last word
      do_reset();
      push_pkt(1, 6, 100);
      push_pkt(1, 2, 200);
      trig = 0;
      drive_inputs();
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (trig == 0 && popped[1] == 2) begin
            trig = 1;
            hold[1] = 3;
            push_pkt(0, 2, 300);
            queue_enable[1] = 1'b0;
            drive_inputs();
         end
      end
      check("mask_words", 256'(acc_q.size()), 256'(8));
      if (acc_q.size() == 8) begin
         for (int i = 0; i < 6; i++) check("mask_q1_first", 256'(acc_q[i].qid), 256'(1));
         check("mask_q0_after", 256'(acc_q[6].word[47:16]), 256'(300));
         check("mask_q0_qid", 256'(acc_q[7].qid), 256'(0));
      end
      check("mask_no_regrant", 256'(fifo[1].size()), 256'(2));
      queue_enable = '1;

      // reset mid-packet, then grant restarts from pointer 0
      do_reset();
      push_pkt(0, 1, 400);
      run(4);
      push_pkt(0, 6, 500);
      drive_inputs();
      for (int i = 0; i < 20 && popped[0] < 3; i++) cycle();
      check("rstmid_started", 256'(popped[0]), 256'(3));
      check("rstmid_busy", 256'(dout_valid), 256'(1));
      do_reset();
      check("rstmid_dout_valid", 256'(dout_valid), 256'(0));
      check("rstmid_pkt_count", 256'(pkt_count), 256'(0));
      check("rstmid_din_ready", 256'(din_ready), 256'(0));
      push_pkt(2, 1, 600);
      push_pkt(0, 1, 700);
      run(5);
      check("rstmid_words", 256'(acc_q.size()), 256'(2));
      if (acc_q.size() == 2) begin
         check("rstmid_first_q0", 256'(acc_q[0].qid), 256'(0));
         check("rstmid_then_q2", 256'(acc_q[1].qid), 256'(2));
      end

      // random traffic, gaps, backpressure and mask changes
      do_reset();
      rdy_mode   = 1;
      gap_pct    = 25;
      seqc       = 2000;
      total_pkts = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(99) < 12) begin
            q = $urandom_range(NQ - 1);
            if (fifo[q].size() < 12) begin
               push_pkt(q, $urandom_range(6, 1), seqc);
               seqc += 10;
               total_pkts++;
            end
         end
         if (i % 64 == 63) queue_enable = NQ'($urandom_range(31));
         cycle();
      end
      queue_enable = '1;
      gap_pct      = 0;
      rdy_mode     = 0;
      run(300);
      left = 0;
      for (int k = 0; k < NQ; k++) left += fifo[k].size();
      check("rand_drained", 256'(left), 256'(0));
      check("rand_pkt_total", 256'(pkt_count), 256'(total_pkts));

      // 8-queue instance: q0 and q7 alternate across the pointer wrap
      din_valid = '0;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      w8[0] = 16'hA002; w8[1] = 16'h7002; w8[2] = 16'hA002;
      din8[0 +: DW8]       = 16'hA002;
      din8[7*DW8 +: DW8]   = 16'h7002;
      din_valid8           = 8'h81;
      exp_r8 = '{8'h01, 8'h80, 8'h01};
      exp_q8 = '{0, 7, 0};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("n8_din_ready", 256'(din_ready8), 256'(exp_r8[k]));
         @(posedge clk);
         #1;
         check("n8_queue_id", 256'(queue_id8), 256'(exp_q8[k]));
         check("n8_dout", 256'(dout8), 256'(w8[k]));
         check("n8_sop", 256'(dout_sop8), 256'(1));
      end
      check("n8_pkt_count", 256'(pkt_count8), 256'(3));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
